// File: rtl/ptw_axi_read_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ptw_axi_read_responder_pkg
// Description : Shared AXI read encodings, responder state encodings and the
//               logb2 sizing helper for the page-table-walk read responder.
// Revision    : 1.0 - initial release
// ============================================================================
package ptw_axi_read_responder_pkg;

  // AXI read response codes
  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_EXOKAY = 2'b01;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  // AR channel constants for a single 8-byte PTE fetch
  localparam logic [2:0] ARSIZE_8B        = 3'd3;
  localparam logic [1:0] ARBURST_INCR     = 2'b01;
  localparam logic [2:0] ARPROT_PRIV_DATA = 3'b001;

  // Responder state encodings
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } ptw_rd_state_t;

  // Number of bits needed to count value-1 (ceiling log2)
  function automatic int logb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ptw_axi_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : ptw_axi_read_responder
// Description : Responder end of the TLB walk port. Turns a one-cycle PTE
//               request pulse into a single-beat 8-byte AXI4 read and returns
//               the PTE (or an error) as a one-cycle response pulse. One
//               request can be held pending while a read is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module ptw_axi_read_responder
  import ptw_axi_read_responder_pkg::*;
#(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int PHYS_ADDR_WIDTH = 56,
  parameter int ID_WIDTH        = 4,
  parameter int AXI_ID          = 0,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  REQ_VALID,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  output logic                  RESP_VALID,
  output logic [DATA_WIDTH-1:0] RESP_DATA,
  output logic                  RESP_ERR,
  output logic                  BUSY,
  output logic [ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RLAST,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam int                     CNT_WIDTH = logb2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_WIDTH-1:0]   CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = {CNT_WIDTH{1'b1}};
  // Any set bit in this mask lies outside the legal physical address space
  localparam logic [ADDR_WIDTH-1:0]  HIGH_MASK = {ADDR_WIDTH{1'b1}} << PHYS_ADDR_WIDTH;

  ptw_rd_state_t          state;
  logic                   pending;
  logic [ADDR_WIDTH-1:0]  pend_addr;
  logic [CNT_WIDTH-1:0]   tmo_cnt;
  // Sticky debug flag: a request arrived while one was already pending.
  // Only observed hierarchically, never drives logic.
  logic                   overflow_dbg_unused;

  logic                   src_valid;
  logic [ADDR_WIDTH-1:0]  src_addr;
  logic                   src_bad;
  logic                   rresp_ok;

  // Fixed AR attributes: one 8-byte beat, privileged secure data access
  assign M_AXI_ARID    = ID_WIDTH'(AXI_ID);
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = ARSIZE_8B;
  assign M_AXI_ARBURST = ARBURST_INCR;
  assign M_AXI_ARPROT  = ARPROT_PRIV_DATA;

  // A pended request has priority over a coincident new one in IDLE
  assign src_valid = pending | REQ_VALID;
  assign src_addr  = pending ? pend_addr : REQ_ADDR;
  assign src_bad   = (src_addr[2:0] != 3'b000) | (|(src_addr & HIGH_MASK));
  assign rresp_ok  = ((M_AXI_RRESP == RRESP_OKAY) || (M_AXI_RRESP == RRESP_EXOKAY)) && M_AXI_RLAST;

  // Pending slot: capture requests that arrive while not IDLE, release when issued
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      pending             <= 1'b0;
      pend_addr           <= '0;
      overflow_dbg_unused <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (pending) begin
        // the pended request issues now; a coincident request takes its slot
        pending <= REQ_VALID;
        if (REQ_VALID) begin
          pend_addr <= REQ_ADDR;
        end
      end
    end else if (REQ_VALID) begin
      if (!pending) begin
        pending   <= 1'b1;
        pend_addr <= REQ_ADDR;
      end else begin
        overflow_dbg_unused <= 1'b1;
      end
    end
  end

  // Walk FSM with registered AXI and response outputs plus the R timeout counter
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state         <= ST_IDLE;
      RESP_VALID    <= 1'b0;
      RESP_ERR      <= 1'b0;
      RESP_DATA     <= '0;
      BUSY          <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_RREADY  <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      RESP_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (src_valid) begin
            if (src_bad) begin
              // illegal address: answer immediately without touching AXI
              RESP_VALID <= 1'b1;
              RESP_ERR   <= 1'b1;
              RESP_DATA  <= '0;
            end else begin
              M_AXI_ARADDR  <= {src_addr[ADDR_WIDTH-1:3], 3'b000};
              M_AXI_ARVALID <= 1'b1;
              BUSY          <= 1'b1;
              state         <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            tmo_cnt       <= '0;
            state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (M_AXI_RVALID) begin
            RESP_VALID   <= 1'b1;
            RESP_ERR     <= ~rresp_ok;
            RESP_DATA    <= rresp_ok ? M_AXI_RDATA : '0;
            M_AXI_RREADY <= 1'b0;
            BUSY         <= 1'b0;
            state        <= ST_IDLE;
          end else if (tmo_cnt == CNT_LAST) begin
            // give up on the beat; keep RREADY high so the late beat is sunk
            RESP_VALID <= 1'b1;
            RESP_ERR   <= 1'b1;
            RESP_DATA  <= '0;
            state      <= ST_DRAIN;
          end else if (tmo_cnt != CNT_MAX) begin
            tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            BUSY         <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ptw_axi_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ptw_axi_read_responder
// Description : Self-checking bench for ptw_axi_read_responder with a
//               behavioural AXI read slave and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ptw_axi_read_responder;
  import ptw_axi_read_responder_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        REQ_VALID;
  logic [63:0] REQ_ADDR;
  logic        RESP_VALID;
  logic [63:0] RESP_DATA;
  logic        RESP_ERR;
  logic        BUSY;
  logic [3:0]  M_AXI_ARID;
  logic [63:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [63:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  ptw_axi_read_responder #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .PHYS_ADDR_WIDTH(56),
    .ID_WIDTH(4), .AXI_ID(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
    .RESP_VALID(RESP_VALID), .RESP_DATA(RESP_DATA), .RESP_ERR(RESP_ERR), .BUSY(BUSY),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 CLK = ~CLK;

  typedef struct { int cyc; logic err; logic [63:0] data; } resp_t;
  typedef struct { int cyc; logic [63:0] addr; } ar_t;
  resp_t exp_q[$];
  resp_t obs_q[$];
  ar_t   ar_q[$];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   arv_cycles = 0;
  bit   addr_moved = 1'b0;
  logic arv_prev = 1'b0;
  logic [63:0] arv_addr = '0;

  // slave configuration
  int         ar_wait = 0;
  int         r_wait = 0;
  logic [1:0] r_resp = 2'b00;
  logic       r_last = 1'b1;
  bit         r_hold = 1'b0;

  function automatic logic [63:0] pte_of(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_1008) return 64'h0000_0000_2000_04CF;
    return {a[31:0] ^ 32'hA5A5_0000, a[31:0]};
  endfunction

  // cycle counter
  initial forever begin
    @(posedge CLK);
    cyc = cyc + 1;
  end

  // monitor: record response pulses and ARVALID behaviour
  initial forever begin
    @(negedge CLK);
    if (RESP_VALID === 1'b1) obs_q.push_back(resp_t'{cyc, RESP_ERR, RESP_DATA});
    if (M_AXI_ARVALID === 1'b1) begin
      arv_cycles = arv_cycles + 1;
      if (arv_prev && (M_AXI_ARADDR !== arv_addr)) addr_moved = 1'b1;
      arv_addr = M_AXI_ARADDR;
    end
    arv_prev = M_AXI_ARVALID;
  end

  // behavioural AXI read slave
  initial begin
    int st;
    int cnt;
    logic [63:0] sa;
    st = 0; cnt = 0; sa = '0;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0;
    M_AXI_RRESP = 2'b00; M_AXI_RLAST = 1'b0;
    forever begin
      @(posedge CLK); #1;
      M_AXI_ARREADY = 1'b0;
      if (RSTN !== 1'b1) begin
        M_AXI_RVALID = 1'b0; st = 0; cnt = 0;
      end else if (st == 0) begin
        if (M_AXI_ARVALID === 1'b1) begin
          if (cnt >= ar_wait) begin
            M_AXI_ARREADY = 1'b1;
            ar_q.push_back(ar_t'{cyc, M_AXI_ARADDR});
            sa = M_AXI_ARADDR; st = 1; cnt = 0;
          end else cnt = cnt + 1;
        end
      end else if (st == 2) begin
        M_AXI_RVALID = 1'b0; st = 0; cnt = 0;
      end else begin
        if (r_hold) M_AXI_RVALID = 1'b0;
        else if (cnt >= r_wait) begin
          M_AXI_RVALID = 1'b1; M_AXI_RDATA = pte_of(sa);
          M_AXI_RRESP = r_resp; M_AXI_RLAST = r_last;
          if (M_AXI_RREADY === 1'b1) st = 2;
        end else cnt = cnt + 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic send_req(input logic [63:0] a, output int t);
    REQ_VALID = 1'b1; REQ_ADDR = a; t = cyc;
    tick();
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget, input string nm);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(posedge CLK); k++;
    end
    #2;
    if (obs_q.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_wait: got %0d responses, expected %0d within %0d cycles", nm, obs_q.size(), n, budget);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0; REQ_VALID = 1'b0; REQ_ADDR = '0;
    repeat (3) tick();
    n_cmp++;
    if ({RESP_VALID, RESP_ERR, BUSY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 00000", {RESP_VALID, RESP_ERR, BUSY, M_AXI_ARVALID, M_AXI_RREADY});
    end
    n_cmp++;
    if (RESP_DATA !== 64'd0 || M_AXI_ARADDR !== 64'd0) begin
      n_bad++; $display("FAIL reset_data: RESP_DATA=%h ARADDR=%h expected 0", RESP_DATA, M_AXI_ARADDR);
    end
    n_cmp++;
    if ({M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARPROT} !== {4'd0, 8'd0, 3'd3, 2'b01, 3'b001}) begin
      n_bad++; $display("FAIL ar_consts: got %h expected %h", {M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARPROT}, {4'd0, 8'd0, 3'd3, 2'b01, 3'b001});
    end
    RSTN = 1'b1;
    tick();
  endtask

  task automatic test_aligned();
    int t;
    resp_t e, o;
    ar_wait = 0; r_wait = 0; r_resp = 2'b00; r_last = 1'b1; r_hold = 1'b0;
    ar_q.delete();
    send_req(64'h0000_0000_8000_1008, t);
    exp_q.push_back(resp_t'{t + 3, 1'b0, 64'h0000_0000_2000_04CF});
    n_cmp++;
    if (M_AXI_ARVALID !== 1'b1 || BUSY !== 1'b1 || M_AXI_ARADDR !== 64'h0000_0000_8000_1008) begin
      n_bad++; $display("FAIL aligned_ar: ARVALID=%b BUSY=%b ARADDR=%h expected 1 1 0000000080001008", M_AXI_ARVALID, BUSY, M_AXI_ARADDR);
    end
    wait_obs(1, 20, "aligned");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL aligned_resp: none, expected cyc=%0d err=%b data=%h", e.cyc, e.err, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.err !== e.err || o.data !== e.data) begin
          n_bad++; $display("FAIL aligned_resp: got cyc=%0d err=%b data=%h expected cyc=%0d err=%b data=%h", o.cyc, o.err, o.data, e.cyc, e.err, e.data);
        end
      end
    end
    repeat (3) tick();
    n_cmp++;
    if (RESP_VALID !== 1'b0 || RESP_DATA !== 64'h0000_0000_2000_04CF || obs_q.size() != 0) begin
      n_bad++; $display("FAIL aligned_hold: RESP_VALID=%b RESP_DATA=%h extra=%0d expected 0 00000000200004cf 0", RESP_VALID, RESP_DATA, obs_q.size());
    end
  endtask

  task automatic test_addr_errors();
    logic [63:0] bad [2];
    int t, a0;
    resp_t e, o;
    bad[0] = 64'h0100_0000_0000_0000;
    bad[1] = 64'h0000_0000_8000_1004;
    for (int i = 0; i < 2; i++) begin
      a0 = arv_cycles;
      send_req(bad[i], t);
      exp_q.push_back(resp_t'{t + 1, 1'b1, 64'd0});
      wait_obs(1, 10, "addr_err");
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front(); n_cmp++;
        if (obs_q.size() == 0) begin
          n_bad++; $display("FAIL addr_err_resp[%0d]: none, expected cyc=%0d err=1 data=0", i, e.cyc);
        end else begin
          o = obs_q.pop_front();
          if (o.cyc !== e.cyc || o.err !== e.err || o.data !== e.data) begin
            n_bad++; $display("FAIL addr_err_resp[%0d]: got cyc=%0d err=%b data=%h expected cyc=%0d err=1 data=0", i, o.cyc, o.err, o.data, e.cyc);
          end
        end
      end
      repeat (2) tick();
      n_cmp++;
      if (arv_cycles != a0 || BUSY !== 1'b0) begin
        n_bad++; $display("FAIL addr_err_noaxi[%0d]: ARVALID cycles=%0d BUSY=%b expected 0 0", i, arv_cycles - a0, BUSY);
      end
    end
  endtask

  task automatic test_ar_stall();
    int t, a0;
    resp_t e, o;
    ar_wait = 5; r_resp = 2'b10;
    a0 = arv_cycles; addr_moved = 1'b0;
    send_req(64'h0000_0000_0040_2000, t);
    exp_q.push_back(resp_t'{t + 8, 1'b1, 64'd0});
    wait_obs(1, 30, "ar_stall");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL ar_stall_resp: none, expected cyc=%0d err=1 data=0", e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.err !== e.err || o.data !== e.data) begin
          n_bad++; $display("FAIL ar_stall_resp: got cyc=%0d err=%b data=%h expected cyc=%0d err=1 data=0", o.cyc, o.err, o.data, e.cyc);
        end
      end
    end
    repeat (4) tick();
    n_cmp++;
    if (arv_cycles - a0 != 6 || addr_moved) begin
      n_bad++; $display("FAIL ar_stall_hold: ARVALID cycles=%0d moved=%b expected 6 0", arv_cycles - a0, addr_moved);
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL ar_stall_single: extra responses=%0d expected 0", obs_q.size());
    end
    ar_wait = 0; r_resp = 2'b00;
  endtask

  task automatic test_timeout();
    int t;
    resp_t e, o;
    r_hold = 1'b1;
    ar_q.delete();
    send_req(64'h0000_0000_0030_0008, t);
    exp_q.push_back(resp_t'{t + 18, 1'b1, 64'd0});
    wait_obs(1, 40, "timeout");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL timeout_resp: none, expected cyc=%0d err=1 data=0", e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.err !== e.err || o.data !== e.data) begin
          n_bad++; $display("FAIL timeout_resp: got cyc=%0d err=%b data=%h expected cyc=%0d err=1 data=0", o.cyc, o.err, o.data, e.cyc);
        end
      end
    end
    n_cmp++;
    if (ar_q.size() != 1 || (ar_q.size() == 1 && ar_q[0].cyc != t + 1)) begin
      n_bad++; $display("FAIL timeout_handshake: count=%0d expected 1 at cyc %0d", ar_q.size(), t + 1);
    end
    tick();
    n_cmp++;
    if (BUSY !== 1'b1 || M_AXI_RREADY !== 1'b1 || RESP_VALID !== 1'b0 || dut.state !== ST_DRAIN) begin
      n_bad++; $display("FAIL timeout_drain: BUSY=%b RREADY=%b RESP_VALID=%b state=%0d expected 1 1 0 %0d", BUSY, M_AXI_RREADY, RESP_VALID, dut.state, ST_DRAIN);
    end
    r_hold = 1'b0;
    repeat (6) tick();
    n_cmp++;
    if (obs_q.size() != 0 || BUSY !== 1'b0 || M_AXI_RREADY !== 1'b0) begin
      n_bad++; $display("FAIL timeout_late_beat: extra=%0d BUSY=%b RREADY=%b expected 0 0 0", obs_q.size(), BUSY, M_AXI_RREADY);
    end
  endtask

  task automatic test_back_to_back();
    int ta, tb2, tc;
    resp_t e, o;
    logic [63:0] a, b, c;
    a = 64'h0000_0000_0010_0000; b = 64'h0000_0000_0010_0040; c = 64'h0000_0000_0010_0080;
    r_wait = 3;
    ar_q.delete();
    send_req(a, ta);
    exp_q.push_back(resp_t'{ta + 6, 1'b0, pte_of(a)});
    tick(); tick();
    send_req(b, tb2);
    exp_q.push_back(resp_t'{ta + 12, 1'b0, pte_of(b)});
    send_req(c, tc);
    wait_obs(2, 40, "b2b");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL b2b_resp: none, expected cyc=%0d err=%b data=%h", e.cyc, e.err, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.err !== e.err || o.data !== e.data) begin
          n_bad++; $display("FAIL b2b_resp: got cyc=%0d err=%b data=%h expected cyc=%0d err=%b data=%h", o.cyc, o.err, o.data, e.cyc, e.err, e.data);
        end
      end
    end
    n_cmp++;
    if (ar_q.size() != 2 || (ar_q.size() == 2 && (ar_q[1].cyc != ta + 7 || ar_q[1].addr !== b))) begin
      n_bad++; $display("FAIL b2b_second_ar: count=%0d expected 2 with AR for %h at cyc %0d", ar_q.size(), b, ta + 7);
    end
    repeat (8) tick();
    n_cmp++;
    if (obs_q.size() != 0 || dut.overflow_dbg_unused !== 1'b1) begin
      n_bad++; $display("FAIL b2b_drop: extra=%0d overflow=%b expected 0 1", obs_q.size(), dut.overflow_dbg_unused);
    end
    r_wait = 0;
  endtask

  task automatic test_reset_mid();
    int t;
    resp_t e, o;
    r_hold = 1'b1;
    send_req(64'h0000_0000_0020_0000, t);
    tick(); tick();
    RSTN = 1'b0;
    tick();
    n_cmp++;
    if ({RESP_VALID, RESP_ERR, BUSY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0 || RESP_DATA !== 64'd0 || M_AXI_ARADDR !== 64'd0) begin
      n_bad++; $display("FAIL reset_mid_outputs: ctrl=%b RESP_DATA=%h ARADDR=%h expected all 0", {RESP_VALID, RESP_ERR, BUSY, M_AXI_ARVALID, M_AXI_RREADY}, RESP_DATA, M_AXI_ARADDR);
    end
    n_cmp++;
    if (dut.state !== ST_IDLE || dut.pending !== 1'b0 || dut.overflow_dbg_unused !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_state: state=%0d pending=%b overflow=%b expected 0 0 0", dut.state, dut.pending, dut.overflow_dbg_unused);
    end
    tick();
    RSTN = 1'b1; r_hold = 1'b0;
    tick();
    obs_q.delete(); exp_q.delete();
    send_req(64'h0000_0000_8000_1008, t);
    exp_q.push_back(resp_t'{t + 3, 1'b0, 64'h0000_0000_2000_04CF});
    wait_obs(1, 20, "reset_mid");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL reset_mid_resp: none, expected cyc=%0d err=0 data=%h", e.cyc, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.err !== e.err || o.data !== e.data) begin
          n_bad++; $display("FAIL reset_mid_resp: got cyc=%0d err=%b data=%h expected cyc=%0d err=0 data=%h", o.cyc, o.err, o.data, e.cyc, e.data);
        end
      end
    end
  endtask

  initial begin
    RSTN = 1'b0; REQ_VALID = 1'b0; REQ_ADDR = '0;
    test_reset();
    test_aligned();
    test_addr_errors();
    test_ar_stall();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
